// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl -- job sequencer for an N x N output-stationary GEMM array.
//
// A job runs IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE. CLEAR wipes the
// PE registers for one cycle. FEED streams K operands into the array with the
// usual diagonal skew. DRAIN walks the result rows out of the bottom edge.
// DONE pulses once. A zero-length job skips FEED and DRAIN entirely.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start, k_len    one-cycle job request and reduction length (IDLE only)
//   abort           kills a running job (CLEAR/FEED/DRAIN); the array is wiped
//                   in the IDLE cycle that follows
//   pe_state        PE mode bus, fixed at GEMM (2'b00)
//   sync_reset      clears PE buffer/input/product registers
//   a_en, b_en      skewed row/column operand feed enables
//   gemm_valid      accumulate enable per anti-diagonal d = i + j
//   drain_valid,
//   drain_row       result row leaving the array and its index
//   busy, done      job in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KW-1:0]        k_len,
  output logic [1:0]           pe_state,
  output logic                 sync_reset,
  output logic [N-1:0]         a_en,
  output logic [N-1:0]         b_en,
  output logic [2*N-2:0]       gemm_valid,
  output logic                 drain_valid,
  output logic [$clog2(N)-1:0] drain_row,
  output logic                 busy,
  output logic                 done
);

  // Counter width holds kq + 2N - 3 even when kq is at its maximum.
  localparam int CW = KW + $clog2(2*N);
  localparam int RW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   kq_q, kq_d;
  logic            abort_q, abort_d;

  logic [CW-1:0]   kq_ext;
  logic [CW-1:0]   feed_last;

  assign kq_ext    = CW'(kq_q);
  // Index of the final FEED cycle: F - 1 = kq + 2N - 3.
  assign feed_last = kq_ext + CW'(2*N - 3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kq_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kq_q    <= kq_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kq_d        = kq_q;
    abort_d     = 1'b0;
    pe_state    = 2'b00;
    sync_reset  = 1'b0;
    a_en        = '0;
    b_en        = '0;
    gemm_valid  = '0;
    drain_valid = 1'b0;
    drain_row   = '0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort_q marks the cleanup cycle after an aborted job.
        sync_reset = abort_q;
        if (start) begin
          state_d = S_CLEAR;
          kq_d    = k_len;
          cnt_d   = '0;
        end
      end

      S_CLEAR: begin
        sync_reset = 1'b1;
        busy       = 1'b1;
        cnt_d      = '0;
        if (abort) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (kq_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FEED;
        end
      end

      S_FEED: begin
        busy = 1'b1;
        // Lane x is active for the kq cycles starting at skew offset x.
        for (int i = 0; i < N; i++) begin
          a_en[i] = (cnt_q >= CW'(i)) && (cnt_q < CW'(i) + kq_ext);
          b_en[i] = (cnt_q >= CW'(i)) && (cnt_q < CW'(i) + kq_ext);
        end
        for (int d = 0; d < 2*N-1; d++) begin
          gemm_valid[d] = (cnt_q >= CW'(d)) && (cnt_q < CW'(d) + kq_ext);
        end
        // Abort wins over expiry of the feed counter.
        if (abort) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cnt_q == feed_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DRAIN: begin
        busy        = 1'b1;
        drain_valid = 1'b1;
        drain_row   = RW'(cnt_q);
        if (abort) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cnt_q == CW'(N-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, the PE array dimension (N x N, N >= 2).
REQ-002 SHALL have parameter KW, default 8, the width of the reduction-length input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle job request, accepted only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminates a running job.
REQ-007 SHALL have port k_len, input, KW bits: reduction length K, sampled when start is accepted.
REQ-008 SHALL have port pe_state, output, 2 bits: the PE mode bus, always 2'b00 (GEMM).
REQ-009 SHALL have port sync_reset, output, 1 bit: clears the PE buffer, input and product registers.
REQ-010 SHALL have port a_en, output, N bits: the skewed row-operand feed enable, one bit per row.
REQ-011 SHALL have port b_en, output, N bits: the skewed column-operand feed enable, one bit per column.
REQ-012 SHALL have port gemm_valid, output, 2N-1 bits: the accumulate enable, where bit d drives every PE(i,j) with i+j=d.
REQ-013 SHALL have port drain_valid, output, 1 bit: marks a result row leaving the array bottom.
REQ-014 SHALL have port drain_row, output, clog2(N) bits: the index of the row being drained.
REQ-015 SHALL have port busy, output, 1 bit: a job is in progress.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle job-completion pulse.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, FEED, DRAIN and DONE, all registered.
REQ-018 SHALL, in IDLE, go to CLEAR on start=1, latching k_len into an internal register kq.
REQ-019 SHALL spend exactly 1 cycle in CLEAR with sync_reset=1, then enter FEED, or enter DONE directly when kq=0.
REQ-020 SHALL keep sync_reset=0 in every state other than CLEAR and the abort case of REQ-027.
REQ-021 SHALL run FEED for F = kq + 2N - 2 cycles, indexed f = 0..F-1 by a counter of width KW+clog2(2N) bits, so that it never overflows at kq = 2^KW - 1.
REQ-022 SHALL, in FEED, drive a_en[i]=1 iff i <= f < i+kq, drive b_en[j]=1 iff j <= f < j+kq, and drive gemm_valid[d]=1 iff d <= f < d+kq; all three are 0 outside FEED.
REQ-023 SHALL run DRAIN for exactly N cycles with gemm_valid all 0, drain_valid=1 and drain_row=0..N-1 in successive cycles.
REQ-024 SHALL spend exactly 1 cycle in DONE with done=1, then return to IDLE.
REQ-025 SHALL drive busy=1 in CLEAR, FEED and DRAIN, and busy=0 in IDLE and DONE.
REQ-026 SHALL ignore start in every state except IDLE, including DONE; start and k_len are not sampled in those states.
REQ-027 SHALL, on abort=1 in CLEAR, FEED or DRAIN, go to IDLE on the next cycle with sync_reset=1 for that cycle, all enables 0, and no done pulse.
REQ-028 SHALL ignore abort in IDLE and DONE.
REQ-029 SHALL give abort priority over counter expiry when both occur in the same cycle.
REQ-030 SHALL drive sync_reset=1 in the IDLE cycle that follows an abort.
REQ-031 SHALL make the latency from start (sampled at edge 0) to the done pulse exactly 1 + F + N + 1 cycles for kq > 0, and 2 cycles for kq = 0.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, enter IDLE and clear kq and all counters.
REQ-033 SHALL, while in reset, drive sync_reset=0, a_en=0, b_en=0, gemm_valid=0, drain_valid=0, drain_row=0, busy=0 and done=0.
REQ-034 SHALL, while in reset, keep pe_state=2'b00.
REQ-035 SHALL give rst priority over start and abort.
REQ-036 SHALL, when rst is asserted mid-job, drop the job without a done pulse and never resume it.
REQ-037 SHALL not drive sync_reset=1 on exit from reset.

Verification
REQ-038 SHALL cover: N=4, k_len=3, start at cycle 0 -> sync_reset=1 at cycle 1, FEED at cycles 2-10, gemm_valid[6]=1 only at cycles 8-10, drain_row=0..3 at cycles 11-14, done=1 at cycle 15 only.
REQ-039 SHALL cover: N=4, k_len=3 -> a_en[0]=1 at cycles 2-4 and a_en[3]=1 at cycles 5-7, with b_en equal to a_en in every cycle.
REQ-040 SHALL cover: k_len=0 -> sync_reset at cycle 1, done at cycle 2, and a_en, b_en and gemm_valid never asserted.
REQ-041 SHALL cover: abort at FEED cycle f=4 -> sync_reset=1 and IDLE on the next cycle, done never asserted, and a new start accepted immediately after.
REQ-042 SHALL cover: start pulsed while busy, and again in the DONE cycle -> both ignored, with the job timing unchanged.
REQ-043 SHALL cover: rst=1 during DRAIN -> all outputs at their reset values on the next cycle, and no done pulse.
